// File: rtl/ram_stream_reader_if.sv
`default_nettype none
// ============================================================================
//  Module   : ram_stream_reader_if
//  Purpose  : RAM read port plus AXI-stream master bundle for ram_stream_reader.
//  Revision : 1.0  initial release
// ============================================================================
interface ram_stream_reader_if #(
    parameter int DATA_WIDTH = 36,
    parameter int AW         = 10
);
    logic [AW-1:0]         raddr;
    logic                  oe;
    logic [DATA_WIDTH-1:0] rdata;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;

    modport master (
        output raddr,
        output oe,
        input  rdata,
        output m_axis_tdata,
        output m_axis_tvalid,
        input  m_axis_tready,
        output m_axis_tlast
    );

    modport slave (
        input  raddr,
        input  oe,
        output rdata,
        input  m_axis_tdata,
        input  m_axis_tvalid,
        output m_axis_tready,
        input  m_axis_tlast
    );
endinterface
`default_nettype wire

// File: rtl/ram_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : ram_stream_reader
//  Purpose  : Reads a wrapping block of RAM words and emits them as a stream.
//  Revision : 1.0  initial release
// ============================================================================
module ram_stream_reader #(
    parameter  int DATA_WIDTH = 36,
    parameter  int RAM_DEPTH  = 1024,
    localparam int AW         = $clog2(RAM_DEPTH)
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          start,
    input  wire logic [AW-1:0] base_addr,
    input  wire logic [AW:0]   length,
    output logic               busy,
    output logic               done,
    ram_stream_reader_if.master bus
);

    localparam logic [AW:0] C_MAX_LEN = (AW+1)'(RAM_DEPTH);
    localparam logic [AW:0] C_ONE_LEN = (AW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  oe_q, oe_d;
    logic                  oe_last_q, oe_last_d;
    logic                  land_q, land_d;
    logic                  land_last_q, land_last_d;
    logic [AW-1:0]         raddr_q, raddr_d;
    logic [AW:0]           rem_q, rem_d;
    logic [DATA_WIDTH-1:0] fifo_data_q [2];
    logic [DATA_WIDTH-1:0] fifo_data_d [2];
    logic [1:0]            fifo_last_q, fifo_last_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic [1:0]            cnt_q, cnt_d;

    logic                  w_tvalid;
    logic                  w_pop;
    logic                  w_fifo_pop;
    logic                  w_push;
    logic                  w_len_ok;
    logic                  w_room;
    logic [2:0]            w_pend;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic                  w_head_last;

    // A word landing from the RAM is presented directly when the buffer is
    // empty, so the first beat appears in the same cycle as rdata.
    always_comb begin
        w_head_data = '0;
        w_head_last = 1'b0;
        if (cnt_q != 2'd0) begin
            w_head_data = fifo_data_q[rd_ptr_q];
            w_head_last = fifo_last_q[rd_ptr_q];
        end else if (land_q) begin
            w_head_data = bus.rdata;
            w_head_last = land_last_q;
        end
    end

    assign w_tvalid   = (cnt_q != 2'd0) | land_q;
    assign w_pop      = w_tvalid & bus.m_axis_tready;
    assign w_fifo_pop = w_pop & (cnt_q != 2'd0);
    assign w_push     = land_q & ~(w_pop & (cnt_q == 2'd0));
    assign w_len_ok   = (length != '0) && (length <= C_MAX_LEN);

    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        if (w_push) begin
            fifo_data_d[wr_ptr_q] = bus.rdata;
            fifo_last_d[wr_ptr_q] = land_last_q;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (w_fifo_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d       = cnt_q + {1'b0, w_push} - {1'b0, w_fifo_pop};
        land_d      = oe_q;
        land_last_d = oe_q & oe_last_q;
    end

    // A new read lands two cycles out; allow it only if at most one word can
    // still be held by then, so the buffer never overflows under stall.
    assign w_pend = {1'b0, cnt_d} + {2'b00, oe_q};
    assign w_room = (w_pend < 3'd2);

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        oe_d      = 1'b0;
        oe_last_d = 1'b0;
        raddr_d   = raddr_q;
        rem_d     = rem_q;
        case (state_q)
            S_IDLE: begin
                if (start && w_len_ok) begin
                    state_d   = S_RUN;
                    busy_d    = 1'b1;
                    oe_d      = 1'b1;
                    raddr_d   = base_addr;
                    rem_d     = length - C_ONE_LEN;
                    oe_last_d = (length == C_ONE_LEN);
                end
            end
            S_RUN: begin
                if (rem_q == '0) begin
                    state_d = S_FLUSH;
                end else if (w_room) begin
                    oe_d      = 1'b1;
                    raddr_d   = raddr_q + AW'(1);
                    rem_d     = rem_q - C_ONE_LEN;
                    oe_last_d = (rem_q == C_ONE_LEN);
                end
            end
            S_FLUSH: begin
                if (done_q) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if ((cnt_d == 2'd0) && !oe_q) begin
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            oe_q           <= 1'b0;
            oe_last_q      <= 1'b0;
            land_q         <= 1'b0;
            land_last_q    <= 1'b0;
            raddr_q        <= '0;
            rem_q          <= '0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_last_q    <= '0;
            rd_ptr_q       <= 1'b0;
            wr_ptr_q       <= 1'b0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            oe_q           <= oe_d;
            oe_last_q      <= oe_last_d;
            land_q         <= land_d;
            land_last_q    <= land_last_d;
            raddr_q        <= raddr_d;
            rem_q          <= rem_d;
            fifo_data_q[0] <= fifo_data_d[0];
            fifo_data_q[1] <= fifo_data_d[1];
            fifo_last_q    <= fifo_last_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            cnt_q          <= cnt_d;
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign bus.raddr         = raddr_q;
    assign bus.oe            = oe_q;
    assign bus.m_axis_tvalid = w_tvalid;
    assign bus.m_axis_tdata  = w_head_data;
    assign bus.m_axis_tlast  = w_head_last;

endmodule
`default_nettype wire

// File: tb/tb_ram_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_stream_reader
//  Purpose  : Directed, table-driven bench for ram_stream_reader (RAM holds i).
//  Revision : 1.0  initial release
// ============================================================================
module tb_ram_stream_reader;

    localparam int DATA_WIDTH = 36;
    localparam int RAM_DEPTH  = 1024;
    localparam int AW         = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;

    ram_stream_reader_if #(.DATA_WIDTH(DATA_WIDTH), .AW(AW)) bus ();

    ram_stream_reader #(
        .DATA_WIDTH(DATA_WIDTH),
        .RAM_DEPTH (RAM_DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base_addr(base_addr),
        .length   (length),
        .busy     (busy),
        .done     (done),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // RAM model: ram[i] = i, one-cycle read latency, junk when not enabled.
    always @(posedge clk) begin
        bus.rdata <= bus.oe ? DATA_WIDTH'(bus.raddr) : 36'hF_DEAD_BEEF;
    end

    typedef struct {
        logic [AW-1:0]         base;
        logic [AW:0]           len;
        logic [31:0]           rdy_pat;
        int                    restart_cyc;
        logic [DATA_WIDTH-1:0] exp_first;
        logic [DATA_WIDTH-1:0] exp_last;
        int                    exp_done;
    } vec_t;

    vec_t vecs [7];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},   busy, 0);
        chk({tag, "_done"},   done, 0);
        chk({tag, "_oe"},     bus.oe, 0);
        chk({tag, "_raddr"},  bus.raddr, 0);
        chk({tag, "_tvalid"}, bus.m_axis_tvalid, 0);
        chk({tag, "_tlast"},  bus.m_axis_tlast, 0);
        chk({tag, "_tdata"},  bus.m_axis_tdata, 0);
    endtask

    // Caller is positioned at a negedge; the start pulse goes out in that cycle.
    task automatic run_read(input vec_t v);
        int                    issued = 0;
        int                    beats  = 0;
        int                    first_oe = -1;
        int                    first_tv = -1;
        int                    last_hs  = -1;
        int                    done_cyc = -1;
        int                    budget;
        logic                  prev_stall = 1'b0;
        logic [DATA_WIDTH-1:0] prev_data  = '0;
        logic                  prev_last  = 1'b0;
        logic [DATA_WIDTH-1:0] first_data = '0;
        logic [DATA_WIDTH-1:0] last_data  = '0;

        start             = 1'b1;
        base_addr         = v.base;
        length            = v.len;
        bus.m_axis_tready = v.rdy_pat[0];
        chk("busy_before_start", busy, 0);
        budget = 4 * int'(v.len) + 60;

        for (int c = 1; c <= budget && done_cyc < 0; c++) begin
            @(negedge clk);
            start = (c == v.restart_cyc);
            if (c == v.restart_cyc) begin
                base_addr = 10'h200;
                length    = 11'd3;
            end
            bus.m_axis_tready = v.rdy_pat[c % 32];
            if (bus.oe) begin
                if (first_oe < 0) first_oe = c;
                chk("oe_pending_below_2", (issued - beats) <= 1, 1);
                chk("raddr", bus.raddr, (int'(v.base) + issued) % RAM_DEPTH);
                issued++;
            end
            if (prev_stall) begin
                chk("stall_tvalid_hold", bus.m_axis_tvalid, 1);
                chk("stall_tdata_tlast_hold", {bus.m_axis_tdata, bus.m_axis_tlast},
                    {prev_data, prev_last});
            end
            if (bus.m_axis_tvalid) begin
                if (first_tv < 0) first_tv = c;
                if (bus.m_axis_tready) begin
                    chk("tdata", bus.m_axis_tdata, (int'(v.base) + beats) % RAM_DEPTH);
                    chk("tlast", bus.m_axis_tlast, beats == int'(v.len) - 1);
                    if (beats == 0) first_data = bus.m_axis_tdata;
                    last_data = bus.m_axis_tdata;
                    beats++;
                    last_hs = c;
                end
            end
            prev_stall = bus.m_axis_tvalid & ~bus.m_axis_tready;
            prev_data  = bus.m_axis_tdata;
            prev_last  = bus.m_axis_tlast;
            if (done) begin
                done_cyc = c;
                chk("done_after_last_handshake", c, last_hs + 1);
                chk("beats_at_done", beats, int'(v.len));
                chk("busy_with_done", busy, 1);
            end
        end

        start = 1'b0;
        if (done_cyc < 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL done_timeout: no done within %0d cycles (base 0x%0h len %0d), required one",
                     budget, v.base, v.len);
        end else begin
            chk("first_oe_cycle", first_oe, 1);
            chk("first_tvalid_cycle", first_tv, 2);
            chk("first_word", first_data, v.exp_first);
            chk("last_word", last_data, v.exp_last);
            chk("read_count", issued, int'(v.len));
            if (v.exp_done >= 0) chk("done_cycle", done_cyc, v.exp_done);
            @(negedge clk);
            chk("busy_after_done", busy, 0);
            chk("done_single_pulse", done, 0);
        end
    endtask

    task automatic run_ignored(input logic [AW:0] len);
        start     = 1'b1;
        base_addr = 10'h077;
        length    = len;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            chk("ignored_busy", busy, 0);
            chk("ignored_oe", bus.oe, 0);
            chk("ignored_done", done, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int hs;
        int quiet_bad;

        vecs[0] = '{10'h010, 11'd4,    32'hFFFF_FFFF, -1, 36'h010, 36'h013, 6};
        vecs[1] = '{10'h3FE, 11'd4,    32'hFFFF_FFFF, -1, 36'h3FE, 36'h001, 6};
        vecs[2] = '{10'h020, 11'd8,    32'h9999_9999, -1, 36'h020, 36'h027, -1};
        vecs[3] = '{10'h155, 11'd1,    32'hFFFF_FFFF, -1, 36'h155, 36'h155, 3};
        vecs[4] = '{10'h100, 11'd6,    32'hFFFF_FFFF,  3, 36'h100, 36'h105, 8};
        vecs[5] = '{10'h3FF, 11'd2,    32'h5555_5555, -1, 36'h3FF, 36'h000, 5};
        vecs[6] = '{10'h000, 11'd1024, 32'hFFFF_FFFF, -1, 36'h000, 36'h3FF, 1026};

        rst_n             = 1'b0;
        start             = 1'b0;
        base_addr         = '0;
        length            = '0;
        bus.m_axis_tready = 1'b0;

        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_ignored(11'd0);
        run_ignored(11'd1025);

        // Vectors run back to back: each start lands in the cycle busy falls.
        for (int i = 0; i < 7; i++) begin
            run_read(vecs[i]);
        end

        @(negedge clk);
        @(negedge clk);

        // Reset in the middle of an 8-word readout.
        start             = 1'b1;
        base_addr         = 10'h040;
        length            = 11'd8;
        bus.m_axis_tready = 1'b1;
        hs                = 0;
        for (int c = 1; c <= 40 && hs < 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (bus.m_axis_tvalid && bus.m_axis_tready) hs++;
        end
        if (hs < 3) begin
            n_vec++;
            n_miss++;
            $display("FAIL midreset_setup: got %0d handshakes, required 3", hs);
        end
        chk("midreset_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        quiet_bad = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.m_axis_tvalid || done || busy || bus.oe) quiet_bad++;
        end
        chk("post_reset_quiet_cycles_bad", quiet_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 36, width of the RAM word and of the stream data.
REQ-002 Parameter RAM_DEPTH, default 1024, RAM depth in words, power of two; AW = $clog2(RAM_DEPTH).
REQ-003 clk  in  1  single clock; all logic on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 start  in  1  one-cycle request to begin a readout; sampled only in IDLE.
REQ-006 base_addr  in  AW  first RAM address to read; captured with start.
REQ-007 length  in  AW+1  number of words to read, 1..RAM_DEPTH; captured with start.
REQ-008 busy  out  1  high from the cycle after an accepted start until done.
REQ-009 done  out  1  one-cycle pulse after the last word's stream handshake.
REQ-010 raddr  out  AW  RAM read address.
REQ-011 oe  out  1  RAM read enable; RAM returns ram[raddr] exactly one cycle after oe=1.
REQ-012 rdata  in  DATA_WIDTH  RAM read data.
REQ-013 m_axis_tdata  out  DATA_WIDTH  stream data.
REQ-014 m_axis_tvalid  out  1  stream valid.
REQ-015 m_axis_tready  in  1  stream ready.
REQ-016 m_axis_tlast  out  1  high with the final word of a readout.

Function
REQ-017 States: IDLE, RUN, FLUSH; IDLE->RUN on start with 1<=length<=RAM_DEPTH; RUN->FLUSH when the last read is issued; FLUSH->IDLE when the output buffer is empty and no read is in flight, with done=1 in that cycle.
REQ-018 start with length=0 or length>RAM_DEPTH is ignored: no state change, no done.
REQ-019 start while busy=1 is ignored and does not disturb the running readout.
REQ-020 Read k (k=0..length-1) uses raddr = (base_addr + k) mod RAM_DEPTH; the address wraps from RAM_DEPTH-1 to 0.
REQ-021 A 2-entry output buffer holds returned words; oe=1 only in RUN when (buffer occupancy + reads in flight) < 2, or < 2 counting a word popped this cycle.
REQ-022 Returned rdata is written into the buffer the cycle after its oe; no returned word is ever dropped or duplicated.
REQ-023 m_axis_tvalid = buffer not empty; m_axis_tdata/tlast come from the buffer head; a word pops on tvalid&tready.
REQ-024 While tvalid=1 and tready=0, tvalid, tdata and tlast hold stable.
REQ-025 tlast=1 only on word length-1; length=1 gives one word with tlast=1.
REQ-026 Latency: start accepted in cycle 0 -> oe=1, raddr=base_addr in cycle 1 -> tvalid=1 in cycle 2.
REQ-027 With tready held high, throughput is one word per cycle, with no bubbles after the first word.
REQ-028 oe=0 in IDLE and FLUSH; raddr holds its last value when oe=0.
REQ-029 busy falls in the cycle after done; a new start is accepted in that cycle.

Reset
REQ-030 rst_n=0 immediately forces state IDLE, busy=0, done=0, oe=0, raddr=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, and clears the buffer and counters.
REQ-031 Reset during RUN or FLUSH abandons the readout; no done and no further stream words appear after rst_n returns high.

Verification
REQ-032 RAM preloaded with ram[i]=i; base=0x010, length=4, tready=1 -> oe in cycles 1-4, tdata 0x010..0x013 in cycles 2-5, tlast in cycle 5, done in cycle 6.
REQ-033 base=0x3FE, length=4 (RAM_DEPTH=1024) -> tdata 0x3FE, 0x3FF, 0x000, 0x001; tlast on 0x001.
REQ-034 length=8 with tready toggling 1,0,0,1,... -> all 8 words in order, none lost or repeated, tdata stable while stalled, oe never issued with 2 words pending.
REQ-035 length=1 -> single beat with tlast=1, done one cycle after its handshake; length=0 -> busy stays 0, no oe.
REQ-036 start pulsed again mid-readout -> ignored; first readout completes unchanged; start in the cycle busy falls -> accepted.
REQ-037 rst_n asserted after 3 of 8 words -> all outputs at reset values at once; no further tvalid or done after release.
